// File: rtl/usb_dac_demux_pkg.sv
// Shared definitions for the USB-to-DAC packet demultiplexer: parser states,
// default sync byte, header field positions and counter widths.
package usb_dac_demux_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  localparam int WORD_W     = 32;
  localparam int PKT_CNT_W  = 32;
  localparam int ERR_CNT_W  = 16;
  localparam int LEN_W      = 16;
  localparam int ID_FIELD_W = 8;

  localparam int SYNC_MSB = 31;
  localparam int SYNC_LSB = 24;
  localparam int ID_MSB   = 23;
  localparam int ID_LSB   = 16;
  localparam int LEN_MSB  = 15;
  localparam int LEN_LSB  = 0;

  function automatic logic [7:0] hdr_sync(input logic [WORD_W-1:0] w);
    return w[SYNC_MSB:SYNC_LSB];
  endfunction

  function automatic logic [ID_FIELD_W-1:0] hdr_id(input logic [WORD_W-1:0] w);
    return w[ID_MSB:ID_LSB];
  endfunction

  function automatic logic [LEN_W-1:0] hdr_len(input logic [WORD_W-1:0] w);
    return w[LEN_MSB:LEN_LSB];
  endfunction

endpackage

// File: rtl/usb_dac_demux.sv
// Splits a framed 32-bit USB word stream into per-channel DAC FIFO writes.
// Each packet is a header (sync, channel id, length) followed by payload
// words that are forwarded combinationally to the selected channel.
module usb_dac_demux
  import usb_dac_demux_pkg::*;
#(
  parameter int         NUM_CH = 2,
  parameter logic [7:0] SYNC   = SYNC_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [WORD_W-1:0]              usb_data,
  input  logic                           usb_valid,
  output logic                           usb_ready,
  output logic [NUM_CH-1:0][WORD_W-1:0]  ch_rd_data,
  output logic [NUM_CH-1:0]              ch_rd_data_valid,
  input  logic [NUM_CH-1:0]              ch_rd_full,
  output logic [PKT_CNT_W-1:0]           pkt_count,
  output logic [ERR_CNT_W-1:0]           err_count,
  output logic                           busy
);

  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ID_FIELD_W-1:0] NUM_CH_B = ID_FIELD_W'(NUM_CH);

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [LEN_W-1:0]       remaining_q, remaining_d;
  logic [PKT_CNT_W-1:0]   pkt_count_q, pkt_count_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

  logic [NUM_CH-1:0]      ch_sel;
  logic                   accept;

  // One-hot channel select, only live while forwarding a payload.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_sel[gi]           = (state_q == ST_PAYLOAD) && (id_q == ID_W'(gi));
      assign ch_rd_data[gi]       = usb_data;
      assign ch_rd_data_valid[gi] = ch_sel[gi] & accept;
    end
  endgenerate

  // Handshake: HUNT follows enable, PAYLOAD follows the selected FIFO's space,
  // DROP always drains; nothing is consumed while reset is held.
  always_comb begin
    usb_ready = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_HUNT:    usb_ready = enable;
        ST_PAYLOAD: usb_ready = ~|(ch_sel & ch_rd_full);
        ST_DROP:    usb_ready = 1'b1;
        default:    usb_ready = 1'b0;
      endcase
    end
  end

  assign accept    = usb_valid & usb_ready;
  assign busy      = !reset && (state_q == ST_PAYLOAD || state_q == ST_DROP);
  assign pkt_count = pkt_count_q;
  assign err_count = err_count_q;

  // Next-state: header parsing in HUNT, word countdown in PAYLOAD/DROP.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    remaining_d = remaining_q;
    pkt_count_d = pkt_count_q;
    err_count_d = err_count_q;
    if (accept) begin
      case (state_q)
        ST_HUNT: begin
          if (hdr_sync(usb_data) != SYNC) begin
            err_count_d = err_count_q + 1'b1;
          end else if (hdr_len(usb_data) == '0) begin
            // Empty packet completes immediately regardless of its id.
            pkt_count_d = pkt_count_q + 1'b1;
          end else if (hdr_id(usb_data) < NUM_CH_B) begin
            id_d        = ID_W'(hdr_id(usb_data));
            remaining_d = hdr_len(usb_data);
            state_d     = ST_PAYLOAD;
          end else begin
            remaining_d = hdr_len(usb_data);
            err_count_d = err_count_q + 1'b1;
            state_d     = ST_DROP;
          end
        end
        ST_PAYLOAD: begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LEN_W'(1)) begin
            state_d     = ST_HUNT;
            pkt_count_d = pkt_count_q + 1'b1;
          end
        end
        ST_DROP: begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LEN_W'(1)) begin
            state_d = ST_HUNT;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // State and counter registers; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HUNT;
      id_q        <= '0;
      remaining_q <= '0;
      pkt_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      remaining_q <= remaining_d;
      pkt_count_q <= pkt_count_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_usb_dac_demux.sv
// Scoreboard bench for usb_dac_demux: packets are described at packet level,
// the expected channel writes are queued per channel, and a monitor checks
// every strobe the DUT produces.
module tb_usb_dac_demux;

  localparam int NUM_CH = 2;

  logic                          clk = 1'b0;
  logic                          reset;
  logic                          enable;
  logic [31:0]                   usb_data;
  logic                          usb_valid;
  logic                          usb_ready;
  logic [NUM_CH-1:0][31:0]       ch_rd_data;
  logic [NUM_CH-1:0]             ch_rd_data_valid;
  logic [NUM_CH-1:0]             ch_rd_full;
  logic [31:0]                   pkt_count;
  logic [15:0]                   err_count;
  logic                          busy;

  usb_dac_demux #(.NUM_CH(NUM_CH), .SYNC(8'hA5)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .usb_data         (usb_data),
    .usb_valid        (usb_valid),
    .usb_ready        (usb_ready),
    .ch_rd_data       (ch_rd_data),
    .ch_rd_data_valid (ch_rd_data_valid),
    .ch_rd_full       (ch_rd_full),
    .pkt_count        (pkt_count),
    .err_count        (err_count),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] exp_q [NUM_CH][$];
  logic [31:0] m_pkt;
  logic [15:0] m_err;
  bit          rand_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every channel strobe must match the head of that channel's queue
  // and must never hit a full FIFO.
  always @(negedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_rd_data_valid[c] === 1'b1) begin
        checks++;
        if (ch_rd_full[c]) begin
          fails++;
          $display("FAIL write_while_full ch%0d: got full=1 expected full=0", c);
        end else if (exp_q[c].size() == 0) begin
          fails++;
          $display("FAIL unexpected_write ch%0d: got %h expected no write", c, ch_rd_data[c]);
        end else begin
          logic [31:0] e;
          e = exp_q[c].pop_front();
          if (ch_rd_data[c] !== e) begin
            fails++;
            $display("FAIL ch%0d_data: got %h expected %h", c, ch_rd_data[c], e);
          end else begin
            $display("ok   ch%0d write %h", c, e);
          end
        end
      end
    end
  end

  // Present one word and hold it until the DUT takes it (bounded wait).
  task automatic send_word(input logic [31:0] w);
    int cyc;
    bit done;
    cyc = 0;
    done = 0;
    usb_data  = w;
    usb_valid = 1'b1;
    while (!done) begin
      if (rand_mode) begin
        ch_rd_full = NUM_CH'($urandom);
        enable     = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      if (usb_ready) done = 1;
      @(posedge clk);
      #1;
      cyc++;
      if (!done && cyc > 200) begin
        checks++;
        fails++;
        $display("FAIL accept_timeout: got no accept for word %h expected accept", w);
        done = 1;
      end
    end
    usb_valid = 1'b0;
    if (rand_mode) begin
      ch_rd_full = '0;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  // Packet-level reference: a valid packet delivers its payload to its
  // channel and counts; a bad id drops and counts an error; an empty packet
  // just counts; a non-sync word counts an error.
  task automatic emit_pkt(input int id, input int len, input bit rnd, input logic [31:0] base);
    logic [31:0] w;
    send_word({8'hA5, 8'(id), 16'(len)});
    if (len == 0) m_pkt = m_pkt + 1;
    else if (id >= NUM_CH) m_err = m_err + 1;
    for (int i = 0; i < len; i++) begin
      w = rnd ? $urandom : base + 32'(i);
      if (id < NUM_CH) exp_q[id].push_back(w);
      send_word(w);
    end
    if (len != 0 && id < NUM_CH) m_pkt = m_pkt + 1;
  endtask

  task automatic emit_junk(input logic [31:0] w);
    logic [31:0] j;
    j = w;
    if (j[31:24] == 8'hA5) j[31:24] = 8'h5A;
    m_err = m_err + 1;
    send_word(j);
  endtask

  task automatic check_counters(input string tag);
    usb_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check({tag, "_pkt_count"}, pkt_count, m_pkt);
    check({tag, "_err_count"}, 32'(err_count), 32'(m_err));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("%s_ch%0d_pending", tag, c), 32'(exp_q[c].size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    usb_valid = 1'b1;
    enable    = 1'b1;
    usb_data  = 32'hA500_0001;
    @(negedge clk);
    @(negedge clk);
    check("reset_usb_ready", 32'(usb_ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_strobes", 32'(ch_rd_data_valid), 32'd0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    usb_valid = 1'b0;
    m_pkt = '0;
    m_err = '0;
    @(negedge clk);
    check("reset_pkt_count", pkt_count, 32'd0);
    check("reset_err_count", 32'(err_count), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    usb_data   = '0;
    usb_valid  = 1'b0;
    ch_rd_full = '0;
    m_pkt      = '0;
    m_err      = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Basic packet to channel 0.
    emit_pkt(0, 4, 0, 32'd1);
    check_counters("basic");

    // Channel 1 with FIFO full mid-packet.
    send_word(32'hA501_0003);
    exp_q[1].push_back(32'h11);
    send_word(32'h11);
    ch_rd_full = 2'b10;
    usb_valid  = 1'b1;
    usb_data   = 32'h22;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_stall_ready", 32'(usb_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    ch_rd_full = '0;
    exp_q[1].push_back(32'h22);
    send_word(32'h22);
    exp_q[1].push_back(32'h33);
    send_word(32'h33);
    m_pkt = m_pkt + 1;
    check_counters("full_stall");

    // Junk word then a one-word packet, back to back.
    emit_junk(32'h1234_5678);
    emit_pkt(0, 1, 0, 32'd9);
    check_counters("junk");

    // Bad channel id dropped, then a good packet.
    emit_pkt(7, 2, 1, 32'd0);
    emit_pkt(0, 1, 0, 32'hAA);
    check_counters("bad_id");

    // Zero-length packets, including an out-of-range id.
    emit_pkt(9, 0, 0, 32'd0);
    emit_pkt(1, 0, 0, 32'd0);
    check_counters("zero_len");

    // Reset in the middle of a packet.
    send_word(32'hA500_0008);
    for (int i = 0; i < 3; i++) begin
      exp_q[0].push_back(32'h100 + 32'(i));
      send_word(32'h100 + 32'(i));
    end
    do_reset();
    emit_pkt(1, 1, 0, 32'h55);
    check_counters("mid_reset");

    // enable low in HUNT holds off the header.
    enable    = 1'b0;
    usb_valid = 1'b1;
    usb_data  = 32'hA500_0001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("enable_low_ready", 32'(usb_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    enable = 1'b1;
    @(negedge clk);
    check("enable_high_ready", 32'(usb_ready), 32'd1);
    @(posedge clk);
    #1;
    usb_valid = 1'b0;
    exp_q[0].push_back(32'h77);
    send_word(32'h77);
    m_pkt = m_pkt + 1;
    check_counters("enable");

    // Randomised mix with random backpressure and enable.
    rand_mode = 1;
    for (int p = 0; p < 40; p++) begin
      case ($urandom_range(0, 3))
        0: emit_pkt($urandom_range(0, NUM_CH - 1), $urandom_range(1, 6), 1, 32'd0);
        1: emit_pkt($urandom_range(NUM_CH, 255), $urandom_range(1, 5), 1, 32'd0);
        2: emit_pkt($urandom_range(0, 255), 0, 1, 32'd0);
        default: emit_junk($urandom);
      endcase
    end
    rand_mode  = 0;
    enable     = 1'b1;
    ch_rd_full = '0;
    check_counters("random");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/usb_dac_demux.md
USB_DAC_DEMUX -- requirements
Module: usb_dac_demux

Interface
REQ-001 Parameter NUM_CH, default 2, number of DAC channel outputs; channel ids 0..NUM_CH-1.
REQ-002 Parameter SYNC, default 8'hA5, header sync byte.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  accept new packets when high.
REQ-006 usb_data  in  32  word stream from USB read FIFO.
REQ-007 usb_valid  in  1  usb_data holds a word.
REQ-008 usb_ready  out  1  word consumed when usb_valid & usb_ready.
REQ-009 ch_rd_data  out  NUM_CH x 32  per-channel payload word, feeds dac_channel usb_rd_data.
REQ-010 ch_rd_data_valid  out  NUM_CH  per-channel write strobe, feeds usb_rd_data_valid.
REQ-011 ch_rd_full  in  NUM_CH  per-channel FIFO full, from usb_rd_full.
REQ-012 pkt_count  out  32  completed packets.
REQ-013 err_count  out  16  header errors.
REQ-014 busy  out  1  high in PAYLOAD or DROP.

Function
REQ-015 Header word: [31:24]=SYNC, [23:16]=channel id, [15:0]=payload length L in words.
REQ-016 States: HUNT, PAYLOAD, DROP.
REQ-017 HUNT: usb_ready = enable; on accepted word with [31:24]!=SYNC, stay HUNT, err_count+1.
REQ-018 HUNT, accepted header, SYNC ok, id<NUM_CH, L>0: latch id, remaining=L, go PAYLOAD.
REQ-019 HUNT, accepted header, SYNC ok, id>=NUM_CH, L>0: remaining=L, err_count+1, go DROP.
REQ-020 HUNT, accepted header, SYNC ok, L=0: stay HUNT, pkt_count+1 (id not checked).
REQ-021 PAYLOAD: usb_ready = !ch_rd_full[id]; enable ignored until packet ends.
REQ-022 PAYLOAD forward path combinational, zero latency: ch_rd_data[id]=usb_data, ch_rd_data_valid[id]=usb_valid & usb_ready; never write a full channel.
REQ-023 ch_rd_data_valid of every non-selected channel, and of all channels outside PAYLOAD, SHALL be 0; ch_rd_data of all channels SHALL equal usb_data.
REQ-024 DROP: usb_ready=1; accepted words discarded.
REQ-025 PAYLOAD/DROP: each accepted word decrements remaining; accepting word with remaining=1 returns to HUNT next cycle, pkt_count+1 (PAYLOAD only).
REQ-026 Back-to-back: header accepted in the cycle after the last payload word; no idle cycle required.
REQ-027 ch_rd_full rising mid-packet stalls only; remaining and id held.
REQ-028 enable low in HUNT: usb_ready=0, no words consumed.
REQ-029 Counters wrap at all-ones to 0; no saturation.
REQ-030 pkt_count and err_count update on the clock edge after the triggering word is accepted.

Reset
REQ-031 reset forces HUNT, remaining=0, id=0, pkt_count=0, err_count=0.
REQ-032 During reset: usb_ready=0, ch_rd_data_valid=0, busy=0.
REQ-033 Reset mid-packet abandons the packet; the next word after reset is parsed as a header.

Structure
REQ-034 Shared package: state enum, SYNC default, header field bit positions, width constants.
REQ-035 Single module; no sub-module required.

Verification
REQ-036 Header A5_00_0004 then 4 words 1..4, all full=0 -> ch0 strobes 4 consecutive cycles data 1..4, ch1 none, pkt_count=1.
REQ-037 Header A5_01_0003, ch_rd_full[1]=1 for cycles 2-5 of payload -> usb_ready low those cycles, exactly 3 ch1 writes, no write while full.
REQ-038 Words 12345678, A5_00_0001, 9 -> err_count=1, ch0 receives 9 only, pkt_count=1.
REQ-039 Header A5_07_0002, 2 words, then A5_00_0001, AA -> err_count=1, dropped words unseen on all channels, ch0 receives AA.
REQ-040 Header A5_00_0008, reset after 3 payload words, then A5_01_0001, 55 -> counters 0 after reset, ch1 receives 55, pkt_count=1.
REQ-041 enable low with usb_valid high in HUNT -> usb_ready=0 for 10 cycles; enable high -> header accepted next cycle.
